ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//   PS/2 keyboard receiver: samples the device-driven ps2_clk/ps2_data lines, deframes 11-bit frames and pushes scan-code bytes into an 8-slot FIFO.
//   Sits between the PS/2 pads and the scan-code decoder, which pops bytes with a nextdata_n strobe and maps them to ASCII through lookup ROMs.
//   Receive-only; never drives the PS/2 lines.
// PARAMETERS
//   PTR_W      3   FIFO pointer width; 2**PTR_W slots, one kept empty (capacity 7 bytes)
// PORTS
//   clk         in   1  system clock (typ. 50 MHz); all state on rising edge
//   clrn        in   1  reset, asynchronous, active-low
//   ps2_clk     in   1  PS/2 clock from device, asynchronous to clk
//   ps2_data    in   1  PS/2 data from device, asynchronous to clk
//   nextdata_n  in   1  active-low pop request; one byte popped per clk cycle held low while ready=1
//   data        out  8  FIFO head byte; 8'h00 whenever ready=0
//   ready       out  1  FIFO non-empty (w_ptr != r_ptr)
//   overflow    out  1  sticky: a complete frame arrived while FIFO full
// BEHAVIOUR
//   - Reset (clrn=0): w_ptr=r_ptr=0, bit count=0, shift reg=0, sync regs=0, overflow=0 -> ready=0, data=8'h00. FIFO storage not reset.
//   - ps2_clk passes a 3-FF synchronizer; falling edge detected when sync[2:1]==2'b10. ps2_data sampled on that same clk cycle.
//   - Frame: 11 falling edges: start(0), d0..d7 LSB first, odd parity, stop(1). Bit counter 0..10, cleared after the 11th bit.
//   - On the 11th bit: frame valid if start==0, stop==1 (plus parity, see CONFIGURATION).
//     Valid and not full: fifo[w_ptr]<=byte, w_ptr+1. Valid and full ((w_ptr+1)==r_ptr): byte discarded, overflow<=1.
//     Invalid: byte discarded silently; no flag.
//   - ready/data are combinational from registered pointers: ready rises the cycle after the write cycle.
//   - Pop: each clk edge with ready=1 and nextdata_n=0 does r_ptr+1. nextdata_n=0 with ready=0 is ignored.
//   - Simultaneous write and pop in one cycle: both happen; full test uses pre-pop pointers.
//   - Pointers wrap modulo 2**PTR_W. overflow clears only on reset.
//   - Reset mid-frame: partial frame lost; receiver resyncs on the next frame only if the line is idle at reset release. No idle timeout.
// CONFIGURATION
//   PS2_PARITY_CHECK_EN defined: frame also needs ^{d7..d0,parity}==1 (odd); bad parity discards the byte.
//   Undefined: parity bit sampled but ignored.
// TESTING
//   Drive ps2_clk at ~12.5 kHz: change data mid-high, falling edge mid-bit. Hold nextdata_n=1 unless stated.
//   1. Frame 0x1C (parity 0) -> ready=1 within 4 clk of 11th fall, data=8'h1C; nextdata_n low 1 cycle -> ready=0, data=8'h00.
//   2. Burst 0xF0,0x1C -> data=F0; pop -> data=1C; pop -> ready=0; overflow=0 throughout.
//   3. 8 frames 0x01..0x08, no pop -> 0x08 dropped, overflow=1; 7 pops give 01..07, then ready=0; overflow stays 1.
//   4. Frame with start=1 or stop=0 -> ready stays 0, overflow=0.
//   5. 0x1C with parity=1 -> dropped if PS2_PARITY_CHECK_EN defined, else data=8'h1C.
//   6. clrn low after 5 bits, then full frame 0x29 -> only 0x29 received; overflow=0.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - scan-code FIFO read port between the PS/2 receiver and the decoder
interface ps2_kbd_rx_if;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  modport master (input nextdata_n, output data, ready, overflow);
  modport slave  (output nextdata_n, input data, ready, overflow);
endinterface

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: deframes 11-bit frames into an 8-slot scan-code FIFO
// Optional odd-parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_kbd_rx #(
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master rx
);

  logic [2:0]       clk_sync;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [9:0]       shift, shift_nxt;
  logic [PTR_W-1:0] w_ptr, w_ptr_nxt, w_ptr_inc;
  logic [PTR_W-1:0] r_ptr, r_ptr_nxt;
  logic             overflow_q, overflow_nxt;
  logic             fall, frame_end, frame_ok, full, wr_en, pop;

  logic [7:0] fifo [0:(2**PTR_W)-1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync   <= 3'b000;
      bit_cnt    <= 4'd0;
      shift      <= 10'd0;
      w_ptr      <= '0;
      r_ptr      <= '0;
      overflow_q <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      w_ptr      <= w_ptr_nxt;
      r_ptr      <= r_ptr_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  // Storage carries no reset; only the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) fifo[w_ptr] <= shift[8:1];
  end

  always_comb begin
    fall         = (clk_sync[2:1] == 2'b10);
    frame_end    = fall && (bit_cnt == 4'd10);
    w_ptr_inc    = w_ptr + 1'b1;
    full         = (w_ptr_inc == r_ptr);
    // shift[0] holds start, shift[8:1] the byte, shift[9] parity; stop is the live sample.
`ifdef PS2_PARITY_CHECK_EN
    frame_ok     = !shift[0] && ps2_data && (^shift[9:1]);
`else
    frame_ok     = !shift[0] && ps2_data;
`endif
    wr_en        = frame_end && frame_ok && !full;
    pop          = rx.ready && !rx.nextdata_n;

    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    w_ptr_nxt    = w_ptr;
    r_ptr_nxt    = r_ptr;
    overflow_nxt = overflow_q;

    if (fall) begin
      shift_nxt   = {ps2_data, shift[9:1]};
      bit_cnt_nxt = frame_end ? 4'd0 : bit_cnt + 4'd1;
    end
    if (wr_en) w_ptr_nxt = w_ptr_inc;
    if (frame_end && frame_ok && full) overflow_nxt = 1'b1;
    if (pop) r_ptr_nxt = r_ptr + 1'b1;
  end

  assign rx.ready    = (w_ptr != r_ptr);
  assign rx.data     = rx.ready ? fifo[r_ptr] : 8'h00;
  assign rx.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed and randomized bench for ps2_kbd_rx against a queue-based model
module tb_ps2_kbd_rx;

  localparam int HALF = 20;
  localparam int CAP  = 7;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_rx_if bus ();

  ps2_kbd_rx dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (bus)
  );

  always #10 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
    check({tag, "_ready"}, {31'd0, bus.ready}, {31'd0, mq.size() != 0});
    check({tag, "_data"}, {24'd0, bus.data}, {24'd0, exp_data});
    check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, m_ovf});
  endtask

  function automatic void model_frame(input logic [7:0] d, input logic st, input logic par, input logic sp);
    logic good;
    good = !st && sp;
`ifdef PS2_PARITY_CHECK_EN
    good = good && ((^d) ^ par);
`endif
    if (good) begin
      if (mq.size() < CAP) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  // Sends the first `cut` bits of a frame; a full frame is checked 4 clk after its 11th fall.
  task automatic send_frame(input logic [7:0] d, input logic st, input logic par, input logic sp,
                            input int cut, input string tag);
    logic [10:0] bits;
    bits = {sp, par, d, st};
    for (int i = 0; i < cut; i++) begin
      ps2_data = bits[i];
      wait_clk(HALF / 2);
      ps2_clk = 1'b0;
      if (i == 10) begin
        model_frame(d, st, par, sp);
        wait_clk(4);
        check_outputs(tag);
        wait_clk(HALF - 4);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b1;
      wait_clk(HALF / 2);
    end
    ps2_data = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic good_frame(input logic [7:0] d, input string tag);
    send_frame(d, 1'b0, ~^d, 1'b1, 11, tag);
  endtask

  task automatic pop(input string tag);
    bus.nextdata_n = 1'b0;
    wait_clk(1);
    bus.nextdata_n = 1'b1;
    if (mq.size() != 0) void'(mq.pop_front());
    wait_clk(1);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] d;
    int         kind;
    int         npop;

    bus.nextdata_n = 1'b1;
    wait_clk(3);
    check_outputs("reset");
    clrn = 1'b1;
    wait_clk(5);
    check_outputs("idle");

    good_frame(8'h1C, "t1_frame");
    pop("t1_pop");

    good_frame(8'hF0, "t2_f0");
    good_frame(8'h1C, "t2_1c");
    pop("t2_pop1");
    pop("t2_pop2");
    pop("empty_pop");

    for (int i = 1; i <= 8; i++) good_frame(i[7:0], "t3_fill");
    for (int i = 0; i < 8; i++) pop("t3_drain");

    send_frame(8'h1C, 1'b1, 1'b0, 1'b1, 11, "t4_badstart");
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11, "t4_badstop");

    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11, "t5_badpar");
    pop("t5_pop");

    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 5, "t6_partial");
    clrn = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    wait_clk(3);
    check_outputs("t6_reset");
    clrn = 1'b1;
    wait_clk(5);
    good_frame(8'h29, "t6_frame");
    pop("t6_pop");

    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      kind = $urandom_range(0, 5);
      case (kind)
        0:       send_frame(d, 1'b1, ~^d, 1'b1, 11, "rnd_badstart");
        1:       send_frame(d, 1'b0, ~^d, 1'b0, 11, "rnd_badstop");
        2:       send_frame(d, 1'b0, ^d, 1'b1, 11, "rnd_badpar");
        default: good_frame(d, "rnd_good");
      endcase
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) pop("rnd_pop");
    end
    while (mq.size() != 0) pop("final_drain");
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
